id_operand_scoreboard: RTL and testbench

// - ID-stage operand scoreboard for the 5-stage MIPS pipeline; generalises fixed A/B forwarding muxes to NSRC operands.
// - Tracks every in-flight destination register (age, latency class, long-op flag) from issue to retirement.
// - Per source: selects forwarded operand from E/M/W/LONG result buses or regfile, or raises stall (load-use, long-op, WAW).

---
 rtl/scb_pkg.sv | 19 +
 rtl/operand_fwd_mux.sv | 66 ++++++
 rtl/id_operand_scoreboard.sv | 141 ++++++++++++++
 tb/tb_id_operand_scoreboard.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scb_pkg.sv
// Shared codes for the ID-stage operand scoreboard: forwarding selects, latency
// classes and pipeline age codes.
package scb_pkg;

    localparam logic [2:0] FWD_RF   = 3'd0;
    localparam logic [2:0] FWD_E    = 3'd1;
    localparam logic [2:0] FWD_M    = 3'd2;
    localparam logic [2:0] FWD_W    = 3'd3;
    localparam logic [2:0] FWD_LONG = 3'd4;

    localparam logic [1:0] LAT_ALU  = 2'd0;
    localparam logic [1:0] LAT_LOAD = 2'd1;
    localparam logic [1:0] LAT_LONG = 2'd2;

    localparam logic [1:0] AGE_E = 2'd1;
    localparam logic [1:0] AGE_M = 2'd2;
    localparam logic [1:0] AGE_W = 3'd3;

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand against the scoreboard: picks the forwarding bus
// holding the youngest in-flight value, or flags that the source must stall.
module operand_fwd_mux
    import scb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5
) (
    input  logic [AW-1:0]        src,
    input  logic                 src_use,
    input  logic [NREG-1:0]      pend,
    input  logic [NREG-1:0][1:0] age,
    input  logic [NREG-1:0]      is_load,
    input  logic [NREG-1:0]      is_long,
    input  logic [DATA_W-1:0]    rf_data,
    input  logic [DATA_W-1:0]    e_data,
    input  logic [DATA_W-1:0]    m_data,
    input  logic [DATA_W-1:0]    w_data,
    input  logic                 long_done,
    input  logic [AW-1:0]        long_tag,
    input  logic [DATA_W-1:0]    long_data,
    output logic [DATA_W-1:0]    data,
    output logic [2:0]           sel,
    output logic                 src_stall
);

    always_comb begin
        sel       = FWD_RF;
        src_stall = 1'b0;
        if (src_use && (src != '0) && pend[src]) begin
            if (is_long[src]) begin
                if (long_done && (long_tag == src)) begin
                    sel = FWD_LONG;
                end else begin
                    src_stall = 1'b1;
                end
            end else begin
                case (age[src])
                    AGE_E: begin
                        // Load data only exists from M onwards.
                        if (is_load[src]) begin
                            src_stall = 1'b1;
                        end else begin
                            sel = FWD_E;
                        end
                    end
                    AGE_M:   sel = FWD_M;
                    AGE_W:   sel = FWD_W;
                    default: sel = FWD_RF;
                endcase
            end
        end
    end

    always_comb begin
        case (sel)
            FWD_E:    data = e_data;
            FWD_M:    data = m_data;
            FWD_W:    data = w_data;
            FWD_LONG: data = long_data;
            default:  data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand scoreboard: tracks in-flight destinations and resolves NSRC operands.
// Optional SCB_STATS_EN adds saturating stall_cnt / long_cnt statistics ports.
module id_operand_scoreboard
    import scb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int NSRC   = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [NSRC*AW-1:0]     id_src,
    input  logic [NSRC-1:0]        id_src_use,
    input  logic [AW-1:0]          id_dst,
    input  logic [1:0]             id_lat,
    input  logic [NSRC*DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0]      e_data,
    input  logic [DATA_W-1:0]      m_data,
    input  logic [DATA_W-1:0]      w_data,
    input  logic                   long_done,
    input  logic [AW-1:0]          long_tag,
    input  logic [DATA_W-1:0]      long_data,
    output logic [NSRC*DATA_W-1:0] op_data,
    output logic [NSRC*3-1:0]      fwd_sel,
    output logic                   stall,
`ifdef SCB_STATS_EN
    output logic [31:0]            stall_cnt,
    output logic [31:0]            long_cnt,
`endif
    output logic                   issue
);

    logic [NREG-1:0]      pend_q, pend_d;
    logic [NREG-1:0]      load_q, load_d;
    logic [NREG-1:0]      long_q, long_d;
    logic [NREG-1:0][1:0] age_q, age_d;
    logic [NSRC-1:0]      src_stall;
    logic                 waw;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        operand_fwd_mux #(
            .DATA_W (DATA_W),
            .NREG   (NREG),
            .AW     (AW)
        ) u_mux (
            .src       (id_src[i*AW +: AW]),
            .src_use   (id_src_use[i]),
            .pend      (pend_q),
            .age       (age_q),
            .is_load   (load_q),
            .is_long   (long_q),
            .rf_data   (rf_data[i*DATA_W +: DATA_W]),
            .e_data    (e_data),
            .m_data    (m_data),
            .w_data    (w_data),
            .long_done (long_done),
            .long_tag  (long_tag),
            .long_data (long_data),
            .data      (op_data[i*DATA_W +: DATA_W]),
            .sel       (fwd_sel[i*3 +: 3]),
            .src_stall (src_stall[i])
        );
    end

    // Long ops write back out of order, so a younger write to the same reg must wait.
    assign waw   = (id_dst != '0) && pend_q[id_dst] && long_q[id_dst];
    assign stall = id_valid && ((|src_stall) || waw);
    assign issue = id_valid && !stall && !freeze && !flush;

    always_comb begin
        pend_d = pend_q;
        load_d = load_q;
        long_d = long_q;
        age_d  = age_q;
        if (flush) begin
            pend_d = '0;
            load_d = '0;
            long_d = '0;
            age_d  = '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (pend_q[r]) begin
                    if (long_q[r]) begin
                        if (long_done && (long_tag == AW'(r))) begin
                            pend_d[r] = 1'b0;
                            long_d[r] = 1'b0;
                        end
                    end else if (age_q[r] == AGE_W) begin
                        // Value lands in the write-first regfile on this edge.
                        pend_d[r] = 1'b0;
                        load_d[r] = 1'b0;
                        age_d[r]  = 2'd0;
                    end else begin
                        age_d[r] = age_q[r] + 2'd1;
                    end
                end
            end
            if (issue && (id_dst != '0)) begin
                pend_d[id_dst] = 1'b1;
                age_d[id_dst]  = AGE_E;
                load_d[id_dst] = (id_lat == LAT_LOAD);
                long_d[id_dst] = (id_lat >= LAT_LONG);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            load_q <= '0;
            long_q <= '0;
            age_q  <= '0;
        end else if (!freeze) begin
            pend_q <= pend_d;
            load_q <= load_d;
            long_q <= long_d;
            age_q  <= age_d;
        end
    end

`ifdef SCB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            long_cnt  <= '0;
        end else if (!freeze) begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((|long_q) && (long_cnt != '1)) begin
                long_cnt <= long_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed bench for id_operand_scoreboard: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_operand_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [2:0] DC = 3'd7;

    localparam logic [DW-1:0] RF0 = 32'hAAAA_0000;
    localparam logic [DW-1:0] RF1 = 32'hBBBB_1111;
    localparam logic [DW-1:0] EV  = 32'hE0E0_0001;
    localparam logic [DW-1:0] MV  = 32'h3030_0002;
    localparam logic [DW-1:0] WV  = 32'h5050_0003;
    localparam logic [DW-1:0] LV  = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n, freeze, flush, id_valid;
    logic [2*AW-1:0] id_src;
    logic [1:0]      id_src_use;
    logic [AW-1:0]   id_dst;
    logic [1:0]      id_lat;
    logic [2*DW-1:0] rf_data;
    logic [DW-1:0]   e_data, m_data, w_data, long_data;
    logic            long_done;
    logic [AW-1:0]   long_tag;
    logic [2*DW-1:0] op_data;
    logic [5:0]      fwd_sel;
    logic            stall, issue;
`ifdef SCB_STATS_EN
    logic [31:0]     stall_cnt, long_cnt;
`endif

    typedef struct {
        string      name;
        logic [2:0] sel0;
        logic [2:0] sel1;
        logic       stall;
        logic       issue;
        logic       cnt_chk;
        int         scnt;
        int         lcnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_operand_scoreboard #(
        .DATA_W (DW),
        .NREG   (32),
        .NSRC   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze     (freeze),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_src     (id_src),
        .id_src_use (id_src_use),
        .id_dst     (id_dst),
        .id_lat     (id_lat),
        .rf_data    (rf_data),
        .e_data     (e_data),
        .m_data     (m_data),
        .w_data     (w_data),
        .long_done  (long_done),
        .long_tag   (long_tag),
        .long_data  (long_data),
        .op_data    (op_data),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
`ifdef SCB_STATS_EN
        .stall_cnt  (stall_cnt),
        .long_cnt   (long_cnt),
`endif
        .issue      (issue)
    );

    function automatic logic [DW-1:0] exp_data(input int i, input logic [2:0] s);
        case (s)
            3'd1:    return EV;
            3'd2:    return MV;
            3'd3:    return WV;
            3'd4:    return LV;
            default: return (i == 0) ? RF0 : RF1;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared here.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int i = 0; i < 2; i++) begin
                logic [2:0] s;
                s = (i == 0) ? e.sel0 : e.sel1;
                if (s != DC) begin
                    cmp({e.name, $sformatf(" sel%0d", i)}, 32'(fwd_sel[i*3 +: 3]), 32'(s));
                    cmp({e.name, $sformatf(" data%0d", i)}, op_data[i*DW +: DW], exp_data(i, s));
                end
            end
            cmp({e.name, " stall"}, 32'(stall), 32'(e.stall));
            cmp({e.name, " issue"}, 32'(issue), 32'(e.issue));
`ifdef SCB_STATS_EN
            if (e.cnt_chk) begin
                cmp({e.name, " stall_cnt"}, stall_cnt, e.scnt);
                cmp({e.name, " long_cnt"}, long_cnt, e.lcnt);
            end
`endif
        end
    end

    task automatic step(input logic rst, input logic v, input logic [AW-1:0] s0,
                        input logic [AW-1:0] s1, input logic [1:0] use_m,
                        input logic [AW-1:0] dst, input logic [1:0] lat, input logic frz,
                        input logic fl, input logic ld, input logic [AW-1:0] tag);
        @(posedge clk);
        #1;
        rst_n      = rst;
        id_valid   = v;
        id_src     = {s1, s0};
        id_src_use = use_m;
        id_dst     = dst;
        id_lat     = lat;
        freeze     = frz;
        flush      = fl;
        long_done  = ld;
        long_tag   = tag;
    endtask

    task automatic expect_out(input string nm, input logic [2:0] s0, input logic [2:0] s1,
                              input logic st, input logic iss);
        exp_t e;
        e = '{name: nm, sel0: s0, sel1: s1, stall: st, issue: iss, cnt_chk: 1'b0,
              scnt: 0, lcnt: 0};
        q.push_back(e);
    endtask

    task automatic expect_cnt(input string nm, input logic [2:0] s0, input logic st,
                              input logic iss, input int sc, input int lc);
        exp_t e;
        e = '{name: nm, sel0: s0, sel1: DC, stall: st, issue: iss, cnt_chk: 1'b1,
              scnt: sc, lcnt: lc};
        q.push_back(e);
    endtask

    initial begin
        rf_data   = {RF1, RF0};
        e_data    = EV;
        m_data    = MV;
        w_data    = WV;
        long_data = LV;
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        step(1, 1, 3, 5, 2'b11, 0, 0, 0, 0, 0, 0);  expect_out("reset", 0, 0, 0, 1);

        // ALU r3 walks E -> M -> W -> RF; src1 = r0 never forwards.
        step(1, 1, 0, 0, 2'b00, 3, 0, 0, 0, 0, 0);  expect_out("alu_issue", 0, 0, 0, 1);
        step(1, 1, 3, 0, 2'b11, 0, 0, 0, 0, 0, 0);  expect_out("alu_e", 1, 0, 0, 1);
        step(1, 1, 3, 0, 2'b11, 0, 0, 0, 0, 0, 0);  expect_out("alu_m", 2, 0, 0, 1);
        step(1, 1, 3, 0, 2'b11, 0, 0, 0, 0, 0, 0);  expect_out("alu_w", 3, 0, 0, 1);
        step(1, 1, 3, 0, 2'b11, 0, 0, 0, 0, 0, 0);  expect_out("alu_rf", 0, 0, 0, 1);

        // Load-use: one stall cycle, then M; stalled ALU r6 allocates on retry.
        step(1, 1, 3, 0, 2'b00, 5, 1, 0, 0, 0, 0);  expect_out("ld_issue", 0, 0, 0, 1);
        step(1, 1, 5, 0, 2'b01, 6, 0, 0, 0, 0, 0);  expect_out("ld_use", DC, 0, 1, 0);
        step(1, 1, 5, 0, 2'b01, 6, 0, 0, 0, 0, 0);  expect_out("ld_m", 2, 0, 0, 1);
        step(1, 1, 5, 6, 2'b11, 0, 0, 0, 0, 0, 0);  expect_out("ld_w_alu_e", 3, 1, 0, 1);

        // LONG r8 holds its consumer until long_done, forwarded the same cycle.
        step(1, 1, 0, 0, 2'b00, 8, 2, 0, 0, 0, 0);  expect_out("long_issue", 0, 0, 0, 1);
        step(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);  expect_out("long_wait1", DC, 0, 1, 0);
        step(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);  expect_out("long_wait2", DC, 0, 1, 0);
        step(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 1, 8);  expect_out("long_done", 4, 0, 0, 1);
        step(1, 1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0);  expect_out("long_retired", 0, 0, 0, 1);

        // WAW behind LONG r8; unused src r8 and src r0 do not forward.
        step(1, 1, 0, 0, 2'b00, 8, 3, 0, 0, 0, 0);  expect_out("long3_issue", 0, 0, 0, 1);
        step(1, 1, 0, 0, 2'b00, 8, 0, 0, 0, 0, 0);  expect_out("waw1", 0, 0, 1, 0);
        step(1, 1, 0, 8, 2'b01, 8, 0, 0, 0, 0, 0);  expect_out("waw2", 0, 0, 1, 0);
        step(1, 0, 0, 8, 2'b00, 8, 0, 0, 0, 1, 8);  expect_out("waw_done", 0, 0, 0, 0);
        step(1, 1, 0, 0, 2'b00, 8, 0, 0, 0, 0, 0);  expect_out("waw_go", 0, 0, 0, 1);

        // Three pending entries, then flush; stale long_done for r10 ignored.
        step(1, 1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0);  expect_out("fl_ld9", 0, 0, 0, 1);
        step(1, 1, 0, 0, 2'b00, 10, 2, 0, 0, 0, 0); expect_out("fl_long10", 0, 0, 0, 1);
        step(1, 1, 9, 10, 2'b11, 0, 0, 0, 1, 0, 0); expect_out("flush", 2, DC, 1, 0);
        step(1, 1, 9, 10, 2'b11, 0, 0, 0, 0, 0, 0); expect_out("post_flush", 0, 0, 0, 1);
        step(1, 1, 8, 10, 2'b11, 0, 0, 0, 0, 1, 10); expect_out("stale_done", 0, 0, 0, 1);

        // Freeze holds an age-1 entry for 4 cycles.
        step(1, 1, 0, 0, 2'b00, 11, 0, 0, 0, 0, 0); expect_out("fz_issue", 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 11, 0, 2'b01, 0, 0, 1, 0, 0, 0);
            expect_out($sformatf("freeze%0d", k), 1, 0, 0, 0);
        end
        step(1, 1, 11, 0, 2'b01, 0, 0, 0, 0, 0, 0); expect_out("fz_release", 1, 0, 0, 1);
        step(1, 1, 11, 0, 2'b01, 0, 0, 0, 0, 0, 0); expect_out("fz_advance", 2, 0, 0, 1);

        // Reset with a pending load, applied under freeze.
        step(1, 1, 0, 0, 2'b00, 12, 1, 0, 0, 0, 0); expect_cnt("pre_rst", 0, 0, 1, 6, 7);
        step(0, 1, 12, 0, 2'b01, 0, 0, 1, 0, 0, 0); expect_out("rst_ld_use", DC, DC, 1, 0);
        step(1, 1, 12, 0, 2'b01, 0, 0, 0, 0, 0, 0); expect_cnt("post_rst", 0, 0, 1, 0, 0);

        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
